// File: rtl/sram_1r1w_pipe.sv
// 1-read/1-write RAM with byte-lane writes, 1/2-cycle read pipeline
// and an optional post-reset clear sequence.
module sram_1r1w_pipe #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    SIZE              = 1024,
    parameter int                    ADDR_WIDTH        = $clog2(SIZE),
    parameter int                    BYTE_WIDTH        = 8,
    parameter int                    READ_LATENCY      = 1,
    parameter                        READ_DURING_WRITE = "NEW_DATA",
    parameter bit                    CLEAR_ON_RESET    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE       = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             init_done,
    input  logic                             read_en,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             read_valid,
    input  logic                             write_en,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_byte_en
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");
    localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (READ_DURING_WRITE != "NEW_DATA" &&
        READ_DURING_WRITE != "OLD_DATA") begin : g_bad_rdw
        $error("READ_DURING_WRITE must be NEW_DATA or OLD_DATA");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    done_q, done_d;

    logic                    wr_go, rd_go;
    logic                    rd_in_range;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic [NB-1:0]           mem_be;
    logic [DATA_WIDTH-1:0]   rd_old, rd_new, rd_word;

    logic                    s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

    logic [DATA_WIDTH-1:0]   mem_q [SIZE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_READY;
            clr_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            done_q    <= done_d;
        end
    end

    // done_q follows the next state so init_done rises on the same edge
    // that completes the final clear write.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
        done_d = (state_d == ST_READY);
    end

    assign init_done   = done_q;
    assign wr_go       = write_en && done_q && ({1'b0, write_addr} < SIZE_W);
    assign rd_go       = read_en && done_q;
    assign rd_in_range = ({1'b0, read_addr} < SIZE_W);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_cnt_q;
        mem_wd = CLEAR_VALUE;
        mem_be = '1;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_go) begin
            mem_we = 1'b1;
            mem_wa = write_addr;
            mem_wd = write_data;
            mem_be = write_byte_en;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_wa][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        mem_wd[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // A colliding write is always to an in-range address, so the merge
    // only ever overlays real memory contents.
    always_comb begin
        rd_old = rd_in_range ? mem_q[read_addr] : '0;
        rd_new = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_go && write_addr == read_addr && write_byte_en[i]) begin
                rd_new[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = NEW_DATA ? rd_new : rd_old;
    end

    always_comb begin
        s1_vld_d  = rd_go;
        s1_data_d = rd_go ? rd_word : s1_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_vld_q, s2_vld_d;
        logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

        always_comb begin
            s2_vld_d  = s1_vld_q;
            s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q  <= s2_vld_d;
                s2_data_q <= s2_data_d;
            end
        end

        assign read_valid = s2_vld_q;
        assign read_data  = s2_data_q;
    end else begin : g_lat1
        assign read_valid = s1_vld_q;
        assign read_data  = s1_data_q;
    end

endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Directed bench: three RAM configurations driven from shared stimulus,
// each checked against its own expected contents.
module tb_sram_1r1w_pipe;

    logic        clk;
    logic        reset;
    logic        read_en;
    logic [3:0]  read_addr;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_byte_en;

    logic        a_init, b_init, c_init;
    logic        a_vld, b_vld, c_vld;
    logic [31:0] a_data, b_data, c_data;

    logic [31:0] ma [16];
    logic [31:0] mb [16];
    logic [31:0] mc [16];

    int n_chk;
    int n_fail;

    // a: 16 words, latency 1, new-data collisions, clears to A5A5A5A5
    sram_1r1w_pipe #(
        .DATA_WIDTH(32), .SIZE(16), .BYTE_WIDTH(8), .READ_LATENCY(1),
        .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE(32'hA5A5A5A5)
    ) u_a (
        .clk(clk), .reset(reset), .init_done(a_init),
        .read_en(read_en), .read_addr(read_addr),
        .read_data(a_data), .read_valid(a_vld),
        .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .write_byte_en(write_byte_en)
    );

    // b: 16 words, latency 2, old-data collisions, clears to 0
    sram_1r1w_pipe #(
        .DATA_WIDTH(32), .SIZE(16), .BYTE_WIDTH(8), .READ_LATENCY(2),
        .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE(32'h0)
    ) u_b (
        .clk(clk), .reset(reset), .init_done(b_init),
        .read_en(read_en), .read_addr(read_addr),
        .read_data(b_data), .read_valid(b_vld),
        .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .write_byte_en(write_byte_en)
    );

    // c: 12 words (non power of two), latency 1, old-data collisions
    sram_1r1w_pipe #(
        .DATA_WIDTH(32), .SIZE(12), .BYTE_WIDTH(8), .READ_LATENCY(1),
        .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE(32'h0)
    ) u_c (
        .clk(clk), .reset(reset), .init_done(c_init),
        .read_en(read_en), .read_addr(read_addr),
        .read_data(c_data), .read_valid(c_vld),
        .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .write_byte_en(write_byte_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            ma[i] = 32'hA5A5A5A5;
            mb[i] = 32'h0;
            mc[i] = 32'h0;
        end
    endtask

    task automatic model_wr(input logic [3:0] wa, input logic [31:0] wd,
                            input logic [3:0] be);
        ma[wa] = merge(ma[wa], wd, be);
        mb[wa] = merge(mb[wa], wd, be);
        if (wa < 4'd12) mc[wa] = merge(mc[wa], wd, be);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be);
        model_wr(wa, wd, be);
        write_en      = 1'b1;
        write_addr    = wa;
        write_data    = wd;
        write_byte_en = be;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    // One read, optionally with a same-edge write; a answers after one
    // edge with new data, c after one edge with old data, b after two.
    task automatic xfer(input logic [3:0] ra, input logic we,
                        input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be);
        logic [31:0] ea, eb, ec;
        ea = (we && wa == ra) ? merge(ma[ra], wd, be) : ma[ra];
        eb = mb[ra];
        ec = (ra < 4'd12) ? mc[ra] : 32'h0;
        if (we) model_wr(wa, wd, be);
        read_en       = 1'b1;
        read_addr     = ra;
        write_en      = we;
        write_addr    = wa;
        write_data    = wd;
        write_byte_en = be;
        @(posedge clk); #1;
        read_en  = 1'b0;
        write_en = 1'b0;
        chk($sformatf("a_vld_%0d", ra), 32'(a_vld), 32'd1);
        chk($sformatf("a_rd_%0d", ra), a_data, ea);
        chk($sformatf("c_vld_%0d", ra), 32'(c_vld), 32'd1);
        chk($sformatf("c_rd_%0d", ra), c_data, ec);
        chk($sformatf("b_vld_early_%0d", ra), 32'(b_vld), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("b_vld_%0d", ra), 32'(b_vld), 32'd1);
        chk($sformatf("b_rd_%0d", ra), b_data, eb);
        chk($sformatf("a_vld_once_%0d", ra), 32'(a_vld), 32'd0);
    endtask

    task automatic run_clear(input string tag);
        for (int i = 1; i <= 16; i++) begin
            write_en      = (i == 5);
            write_addr    = 4'd2;
            write_data    = 32'h12345678;
            write_byte_en = 4'hF;
            read_en       = (i == 6);
            read_addr     = 4'd2;
            @(posedge clk); #1;
            write_en = 1'b0;
            read_en  = 1'b0;
            chk($sformatf("%s_a_init_%0d", tag, i), 32'(a_init),
                32'(i >= 16));
            chk($sformatf("%s_b_init_%0d", tag, i), 32'(b_init),
                32'(i >= 16));
            chk($sformatf("%s_c_init_%0d", tag, i), 32'(c_init),
                32'(i >= 12));
            chk($sformatf("%s_vld_%0d", tag, i),
                32'({a_vld, b_vld, c_vld}), 32'd0);
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        read_en       = 1'b0;
        read_addr     = '0;
        write_en      = 1'b0;
        write_addr    = '0;
        write_data    = '0;
        write_byte_en = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_init", 32'({a_init, b_init, c_init}), 32'd0);
        chk("rst_vld", 32'({a_vld, b_vld, c_vld}), 32'd0);
        chk("rst_a_data", a_data, 32'h0);
        chk("rst_b_data", b_data, 32'h0);
        chk("rst_c_data", c_data, 32'h0);

        reset = 1'b0;
        run_clear("clr");

        for (int i = 0; i < 16; i++) xfer(4'(i), 1'b0, 4'd0, 32'h0, 4'h0);

        wr(4'd3, 32'h11223344, 4'hF);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        xfer(4'd3, 1'b0, 4'd0, 32'h0, 4'h0);
        chk("be_hand_a", a_data, 32'h11BB33DD);

        wr(4'd7, 32'h0, 4'hF);
        xfer(4'd7, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF);
        xfer(4'd7, 1'b0, 4'd0, 32'h0, 4'h0);
        chk("coll_after_b", b_data, 32'hDEADBEEF);
        xfer(4'd7, 1'b1, 4'd7, 32'h01020304, 4'b0011);

        wr(4'd0, 32'h10000000, 4'hF);
        wr(4'd1, 32'h20000001, 4'hF);
        wr(4'd2, 32'h30000002, 4'hF);
        for (int i = 0; i < 5; i++) begin
            read_en   = (i < 3);
            read_addr = 4'(i);
            @(posedge clk); #1;
            read_en = 1'b0;
            case (i)
                0: begin
                    chk("l2_b_vld0", 32'(b_vld), 32'd0);
                    chk("l2_a_d0", a_data, 32'h10000000);
                end
                1: begin
                    chk("l2_b_vld1", 32'(b_vld), 32'd1);
                    chk("l2_b_d1", b_data, 32'h10000000);
                    chk("l2_a_d1", a_data, 32'h20000001);
                end
                2: begin
                    chk("l2_b_vld2", 32'(b_vld), 32'd1);
                    chk("l2_b_d2", b_data, 32'h20000001);
                    chk("l2_a_d2", a_data, 32'h30000002);
                end
                3: begin
                    chk("l2_b_vld3", 32'(b_vld), 32'd1);
                    chk("l2_b_d3", b_data, 32'h30000002);
                    chk("l2_a_vld3", 32'(a_vld), 32'd0);
                end
                default: begin
                    chk("l2_b_vld4", 32'(b_vld), 32'd0);
                    chk("l2_b_hold", b_data, 32'h30000002);
                    chk("l2_a_hold", a_data, 32'h30000002);
                end
            endcase
        end

        wr(4'd13, 32'hCAFEF00D, 4'hF);
        xfer(4'd13, 1'b0, 4'd0, 32'h0, 4'h0);
        for (int i = 0; i < 12; i++) xfer(4'(i), 1'b0, 4'd0, 32'h0, 4'h0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_init", 32'({a_init, b_init, c_init}), 32'd0);
        chk("mid_rst_data", a_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        run_clear("reclr");
        for (int i = 0; i < 16; i++) xfer(4'(i), 1'b0, 4'd0, 32'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_pipe.md
Name: sram_1r1w_pipe

Overview:
Parametrised successor to the simple 1-read/1-write block RAM. It adds per-byte write enables, a selectable 1- or 2-cycle read pipeline with a read_valid strobe, and an optional post-reset clear sequencer with an init_done flag. Caches, tag/valid arrays and FIFOs instantiate it wherever masked writes or a known-zero start state are needed.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
SIZE, 1024, number of words; need not be a power of two.
ADDR_WIDTH, $clog2(SIZE), address width.
BYTE_WIDTH, 8, bits per write-enable lane; the lane count is DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, read latency; 1 or 2 cycles from the read_en edge to read_valid.
READ_DURING_WRITE, "NEW_DATA", same-address read/write collision result: "NEW_DATA" or "OLD_DATA".
CLEAR_ON_RESET, 1, 1 = write CLEAR_VALUE to every word after reset; 0 = no clear.
CLEAR_VALUE, 0, DATA_WIDTH-bit word written during the clear sequence.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
init_done  out  1  high once the RAM accepts requests.
read_en  in  1  read request.
read_addr  in  ADDR_WIDTH  read address.
read_data  out  DATA_WIDTH  read result.
read_valid  out  1  read_data carries a new result this cycle.
write_en  in  1  write request.
write_addr  in  ADDR_WIDTH  write address.
write_data  in  DATA_WIDTH  write data.
write_byte_en  in  DATA_WIDTH/BYTE_WIDTH  lane enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].

Behaviour:
- Reset is asynchronous and active-high. While reset is high: init_done=0, read_valid=0, read_data=0, all pipeline stages are cleared, the clear counter is 0, and the FSM is in CLEAR (or READY when CLEAR_ON_RESET=0). Memory contents are not touched by reset itself.
- FSM states are CLEAR and READY.
  - CLEAR writes CLEAR_VALUE to address clear_cnt, one word per cycle, with clear_cnt running 0..SIZE-1.
  - After the write to SIZE-1 the FSM moves to READY, so init_done rises exactly SIZE cycles after reset deasserts.
  - READY holds until the next reset.
  - A reset asserted mid-clear restarts the sequence at address 0.
- While init_done=0, read_en and write_en are ignored: no memory update, no read_valid. Requesters must gate on init_done.
- With CLEAR_ON_RESET=0, the FSM enters READY while reset is asserted, init_done=1 on the first cycle after reset, and memory contents are X in simulation.
- Write: on a clock edge with write_en=1, init_done=1 and write_addr<SIZE, lane i of the word is updated from write_data only where write_byte_en[i]=1. Other lanes keep their old value. All-zero byte enables mean no change.
- Read: a read_en=1 edge (with init_done=1) captures a result.
  - READ_LATENCY=1: the result and read_valid=1 appear after that edge.
  - READ_LATENCY=2: the result passes through one extra register stage and appears one cycle later.
  - read_valid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous read_valid stream at full throughput.
- read_data holds its last value when no new result is presented.
- Collision (read_en and write_en both high, same address, same edge):
  - NEW_DATA: the result is the merged word, i.e. new lanes where write_byte_en=1 and old lanes elsewhere.
  - OLD_DATA: the result is the pre-write contents.
  - A read at the following edge always sees the written data.
- Out of range (address >= SIZE, non-power-of-two SIZE): the write is dropped; a read returns 0 with read_valid=1.
- Elaboration checks: $error if DATA_WIDTH % BYTE_WIDTH != 0, READ_LATENCY is not 1 or 2, or READ_DURING_WRITE is not one of the two legal strings.

Test Plan:
- SIZE=16, CLEAR_ON_RESET=1, CLEAR_VALUE=32'hA5A5A5A5: deassert reset -> init_done rises after 16 cycles; reading all 16 addresses returns A5A5A5A5. A write issued at cycle 5 of the clear has no effect.
- Write addr 3 = 32'h11223344 with be=4'hF, then write addr 3 = 32'hAABBCCDD with be=4'b0101, then read addr 3 -> 32'h11BB33DD.
- Same-edge write (addr 7, data 32'hDEADBEEF, be=4'hF) and read of addr 7, where the old value is 0: NEW_DATA -> read_data=DEADBEEF; OLD_DATA -> 0.
- READ_LATENCY=2 with reads of addresses 0,1,2 on consecutive edges -> read_valid high for 3 cycles starting 2 cycles after the first read_en; data returned in order.
- Assert reset during cycle 8 of a 16-word clear, then release -> init_done rises 16 cycles after release; all words equal CLEAR_VALUE.
- SIZE=12: write addr 13, then read addr 13 -> read_valid=1 with read_data=0; addresses 0..11 are unchanged.
